sqrt_pipe_arbiter: RTL and testbench

//  Shares one fixed-latency pipelined square-root unit between N_REQ requesters.

---
 rtl/sqrt_pipe_arbiter_if.sv | 28 ++
 rtl/sqrt_pipe_arbiter.sv | 166 ++++++++++++++++
 tb/tb_sqrt_pipe_arbiter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sqrt_pipe_arbiter_if.sv
// Bus bundle between requesters/sqrt unit/consumer and the sqrt_pipe_arbiter.
// The arbiter takes the slave view; the surrounding clients and sqrt unit take the master view.
interface sqrt_pipe_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WL    = 24,
  parameter int WLO   = 24,
  parameter int IDW   = 2
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*WL-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic [WL-1:0]       sq_din;
  logic [WLO-1:0]      sq_dout;
  logic                resp_valid;
  logic                resp_ready;
  logic [WLO-1:0]      resp_data;
  logic [IDW-1:0]      resp_id;

  modport master (
    output req_valid, req_data, sq_dout, resp_ready,
    input  req_ready, sq_din, resp_valid, resp_data, resp_id
  );

  modport slave (
    input  req_valid, req_data, sq_dout, resp_ready,
    output req_ready, sq_din, resp_valid, resp_data, resp_id
  );
endinterface

// File: rtl/sqrt_pipe_arbiter.sv
// Round-robin arbiter feeding a shared fixed-latency sqrt unit, with id tag pipe and
// credit-protected FWFT response FIFO. Define SQRT_ARB_STATS_EN for grant/stall counters.
module sqrt_pipe_arbiter #(
  parameter int N_REQ      = 4,
  parameter int WL         = 24,
  parameter int WLO        = 24,
  parameter int LAT        = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int IDW        = 2
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               CE,
  sqrt_pipe_arbiter_if.slave bus
`ifdef SQRT_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0] stat_grants,
  output logic [15:0]         stat_stall
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + LAT + 1);

  logic [IDW-1:0]   rr_q, rr_d;
  logic [LAT-1:0]   tag_valid_q, tag_valid_d;
  logic [IDW-1:0]   tag_id_q [LAT];
  logic [IDW-1:0]   tag_id_d [LAT];
  logic [WLO-1:0]   mem_data [FIFO_DEPTH];
  logic [IDW-1:0]   mem_id   [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d, inflight;
  logic             credit_ok, grant_any, push, pop, resp_valid_int;
  logic [IDW-1:0]   grant_id;
  logic [N_REQ-1:0] grant_oh;
  logic [WL-1:0]    din_mux;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + CW'(tag_valid_q[i]);
    end
  end

  // Results already queued plus those still in the sqrt pipe must fit in the FIFO.
  assign credit_ok = (count_q + inflight) < CW'(FIFO_DEPTH);

  // nRST gates the grant so req_ready/sq_din drop the moment reset is asserted.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    if (nRST && CE && credit_ok) begin
      for (int k = 1; k <= N_REQ; k++) begin
        if (!grant_any && bus.req_valid[(int'(rr_q) + k) % N_REQ]) begin
          grant_any = 1'b1;
          grant_id  = IDW'((int'(rr_q) + k) % N_REQ);
        end
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    din_mux  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant_oh[i] = grant_any && (grant_id == IDW'(i));
      if (grant_oh[i]) begin
        din_mux = bus.req_data[i*WL +: WL];
      end
    end
  end

  assign rr_d = grant_any ? grant_id : rr_q;

  always_comb begin
    tag_valid_d = tag_valid_q;
    tag_id_d    = tag_id_q;
    if (CE) begin
      tag_valid_d[0] = grant_any;
      tag_id_d[0]    = grant_id;
      for (int i = 1; i < LAT; i++) begin
        tag_valid_d[i] = tag_valid_q[i-1];
        tag_id_d[i]    = tag_id_q[i-1];
      end
    end
  end

  assign resp_valid_int = (count_q != '0);
  assign push           = CE && tag_valid_q[LAT-1];
  assign pop            = resp_valid_int && bus.resp_ready;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_q        <= IDW'(N_REQ - 1);
      tag_valid_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        tag_id_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      rr_q        <= rr_d;
      tag_valid_q <= tag_valid_d;
      tag_id_q    <= tag_id_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage has no reset; occupancy is tracked by the pointers and count only.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_data[wr_ptr_q] <= bus.sq_dout;
      mem_id[wr_ptr_q]   <= tag_id_q[LAT-1];
    end
  end

  assign bus.req_ready  = grant_oh;
  assign bus.sq_din     = din_mux;
  assign bus.resp_valid = resp_valid_int;
  assign bus.resp_data  = resp_valid_int ? mem_data[rd_ptr_q] : '0;
  assign bus.resp_id    = resp_valid_int ? mem_id[rd_ptr_q]   : '0;

`ifdef SQRT_ARB_STATS_EN
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stat_grant
    logic [15:0] grant_cnt_q, grant_cnt_d;

    always_comb begin
      grant_cnt_d = grant_cnt_q;
      if (grant_oh[gi] && grant_cnt_q != 16'hFFFF) begin
        grant_cnt_d = grant_cnt_q + 16'd1;
      end
    end

    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) grant_cnt_q <= '0;
      else       grant_cnt_q <= grant_cnt_d;
    end

    assign stat_grants[gi*16 +: 16] = grant_cnt_q;
  end

  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((|bus.req_valid) && CE && !credit_ok && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stat_stall = stall_cnt_q;
`endif
endmodule

// File: tb/tb_sqrt_pipe_arbiter.sv
// Self-checking bench for sqrt_pipe_arbiter: queue-based reference model checked every cycle,
// a table of arbitration vectors, directed corner sequences and a randomized phase.
module tb_sqrt_pipe_arbiter;
  localparam int N     = 4;
  localparam int WL    = 24;
  localparam int LAT   = 4;
  localparam int DEPTH = 8;

  logic CLK = 1'b0;
  logic nRST;
  logic CE;
  logic [WL-1:0] sq_pipe [LAT] = '{default: '0};

  int n_checks = 0;
  int n_errors = 0;

  sqrt_pipe_arbiter_if #(.N_REQ(N), .WL(WL), .WLO(WL), .IDW(2)) bus ();

`ifdef SQRT_ARB_STATS_EN
  logic [N*16-1:0] stat_grants;
  logic [15:0]     stat_stall;
`endif

  sqrt_pipe_arbiter #(
    .N_REQ(N), .WL(WL), .WLO(WL), .LAT(LAT), .FIFO_DEPTH(DEPTH), .IDW(2)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .CE(CE),
    .bus(bus)
`ifdef SQRT_ARB_STATS_EN
    ,
    .stat_grants(stat_grants),
    .stat_stall(stat_stall)
`endif
  );

  always #5 CLK = ~CLK;

  // sqrt unit stand-in: LAT-stage CE-gated delay of din
  always @(posedge CLK) begin
    if (CE) begin
      sq_pipe[0] <= bus.sq_din;
      for (int i = 1; i < LAT; i++) sq_pipe[i] <= sq_pipe[i-1];
    end
  end
  assign bus.sq_dout = sq_pipe[LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int id; logic [WL-1:0] data; int rem; } inf_t;
  typedef struct { int id; logic [WL-1:0] data; } rsp_t;
  inf_t inf_q[$];
  rsp_t fq[$];
  int m_rr = N - 1;
  int m_g;
  logic [N-1:0]  e_rdy;
  logic [WL-1:0] e_din;

  always @(negedge CLK) begin
    if (!nRST) begin
      inf_q.delete();
      fq.delete();
      m_rr = N - 1;
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_sq_din", 32'(bus.sq_din), 32'd0);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_resp_data", 32'(bus.resp_data), 32'd0);
      chk("rst_resp_id", 32'(bus.resp_id), 32'd0);
    end else begin
      m_g = -1;
      if (CE && (fq.size() + inf_q.size() < DEPTH)) begin
        for (int k = 1; k <= N; k++) begin
          if (m_g < 0 && bus.req_valid[(m_rr + k) % N]) m_g = (m_rr + k) % N;
        end
      end
      e_rdy = '0;
      e_din = '0;
      if (m_g >= 0) begin
        e_rdy[m_g] = 1'b1;
        e_din = bus.req_data[m_g*WL +: WL];
      end
      chk("req_ready", 32'(bus.req_ready), 32'(e_rdy));
      chk("sq_din", 32'(bus.sq_din), 32'(e_din));
      chk("resp_valid", 32'(bus.resp_valid), 32'(fq.size() != 0));
      if (fq.size() != 0) begin
        chk("resp_data", 32'(bus.resp_data), 32'(fq[0].data));
        chk("resp_id", 32'(bus.resp_id), 32'(fq[0].id));
      end
      // advance to the state after the coming rising edge
      if (fq.size() != 0 && bus.resp_ready) void'(fq.pop_front());
      if (CE) begin
        foreach (inf_q[i]) inf_q[i].rem--;
        while (inf_q.size() != 0 && inf_q[0].rem == 0) begin
          fq.push_back('{inf_q[0].id, inf_q[0].data});
          void'(inf_q.pop_front());
        end
      end
      if (m_g >= 0) begin
        inf_q.push_back('{m_g, e_din, LAT});
        m_rr = m_g;
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic          ce;
    logic [N-1:0]  valid;
    logic [N-1:0]  exp_ready;
    logic [WL-1:0] exp_din;
  } vec_t;
  vec_t tbl[10];

  task automatic drive(input logic [N-1:0] v, input logic ce, input logic rdy);
    @(posedge CLK);
    #1;
    bus.req_valid  = v;
    CE             = ce;
    bus.resp_ready = rdy;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    nRST          = 1'b0;
    bus.req_valid = '0;
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

  initial begin
    int cnt, pops, n;

    tbl[0] = '{1'b1, 4'b0100, 4'b0100, 24'h333333};
    tbl[1] = '{1'b1, 4'b1111, 4'b1000, 24'h444444};
    tbl[2] = '{1'b1, 4'b1111, 4'b0001, 24'h111111};
    tbl[3] = '{1'b0, 4'b1111, 4'b0000, 24'h000000};
    tbl[4] = '{1'b1, 4'b0000, 4'b0000, 24'h000000};
    tbl[5] = '{1'b1, 4'b0110, 4'b0010, 24'h222222};
    tbl[6] = '{1'b1, 4'b0011, 4'b0001, 24'h111111};
    tbl[7] = '{1'b1, 4'b1001, 4'b1000, 24'h444444};
    tbl[8] = '{1'b1, 4'b1001, 4'b0001, 24'h111111};
    tbl[9] = '{1'b1, 4'b1110, 4'b0010, 24'h222222};

    nRST           = 1'b0;
    CE             = 1'b1;
    bus.req_valid  = '0;
    bus.req_data   = {24'h444444, 24'h333333, 24'h222222, 24'h111111};
    bus.resp_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;

    // table: arbitration order from reset (rr starts at N-1)
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].valid, tbl[i].ce, 1'b1);
      chk($sformatf("tbl%0d_ready", i), 32'(bus.req_ready), 32'(tbl[i].exp_ready));
      chk($sformatf("tbl%0d_din", i), 32'(bus.sq_din), 32'(tbl[i].exp_din));
    end
    repeat (12) drive('0, 1'b1, 1'b1);

    // single request latency
    bus.req_data[2*WL +: WL] = 24'h800000;
    drive(4'b0100, 1'b1, 1'b1);
    chk("t1_grant", 32'(bus.req_ready), 32'b0100);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      drive('0, 1'b1, 1'b1);
      n++;
      if (bus.resp_valid) break;
    end
    chk("t1_latency", 32'(n), 32'd5);
    chk("t1_data", 32'(bus.resp_data), 32'h800000);
    chk("t1_id", 32'(bus.resp_id), 32'd2);
    repeat (4) drive('0, 1'b1, 1'b1);

    // round robin with all requesters busy
    do_reset();
    for (int k = 0; k < 12; k++) begin
      drive(4'b1111, 1'b1, 1'b1);
      chk($sformatf("t2_rr%0d", k), 32'(bus.req_ready), 32'(1 << (k % 4)));
    end
    repeat (10) drive('0, 1'b1, 1'b1);

    // backpressure: credit limits to FIFO depth
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      drive(4'b1111, 1'b1, 1'b0);
      if (bus.req_ready != '0) cnt++;
    end
    chk("t3_fill_grants", 32'(cnt), 32'd8);
    chk("t3_blocked", 32'(bus.req_ready), 32'd0);

    // full FIFO: pop one, regrant, then push and pop in the same cycle
    drive('0, 1'b1, 1'b1);
    drive(4'b1111, 1'b1, 1'b0);
    chk("t5_regrant", 32'($countones(bus.req_ready)), 32'd1);
    for (int k = 0; k < 3; k++) begin
      drive(4'b1111, 1'b1, 1'b0);
      chk("t5_nocredit", 32'(bus.req_ready), 32'd0);
    end
    drive('0, 1'b1, 1'b1);
    drive('0, 1'b1, 1'b0);
    pops = 0;
    for (int k = 0; k < 20; k++) begin
      drive('0, 1'b1, 1'b1);
      if (!bus.resp_valid) break;
      pops++;
    end
    chk("t5_drain", 32'(pops), 32'd7);

    // grants resume at full rate once the consumer is ready
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      drive(4'b1111, 1'b1, 1'b1);
      if (bus.req_ready != '0) cnt++;
    end
    chk("t3_resume_grants", 32'(cnt), 32'd20);

    // CE gating mid-stream
    for (int k = 0; k < 3; k++) begin
      drive(4'b1111, 1'b0, 1'b1);
      chk("t4_ce_nogrant", 32'(bus.req_ready), 32'd0);
    end
    repeat (6) drive(4'b1111, 1'b1, 1'b1);
    repeat (10) drive('0, 1'b1, 1'b1);

    // asynchronous reset with work in flight and queued
    do_reset();
    repeat (6) drive(4'b1111, 1'b1, 1'b0);
    chk("t6_pre_valid", 32'(bus.resp_valid), 32'd1);
    @(posedge CLK);
    #1;
    nRST = 1'b0;
    #1;
    chk("t6_ready0", 32'(bus.req_ready), 32'd0);
    chk("t6_valid0", 32'(bus.resp_valid), 32'd0);
    chk("t6_data0", 32'(bus.resp_data), 32'd0);
    chk("t6_id0", 32'(bus.resp_id), 32'd0);
    chk("t6_din0", 32'(bus.sq_din), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    nRST           = 1'b1;
    bus.resp_ready = 1'b1;
    @(negedge CLK);
    chk("t6_first_grant", 32'(bus.req_ready), 32'b0001);
    repeat (12) drive('0, 1'b1, 1'b1);

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      @(posedge CLK);
      #1;
      bus.req_valid  = 4'($urandom_range(0, 15));
      bus.req_data   = {24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom)};
      CE             = ($urandom_range(0, 9) != 0);
      bus.resp_ready = ($urandom_range(0, 2) != 0);
      @(negedge CLK);
    end
    repeat (25) drive('0, 1'b1, 1'b1);
    chk("end_empty", 32'(bus.resp_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
